fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage of the 5-stage MIPS core, directly upstream of the main decoder.
//  - Owns the PC and drives a req/ack instruction-memory port.
//  - Holds the IF/ID register (instrD/pcD/validD); the decoder slices op/rs/rt from instrD.
//  - Supports decode stall, exception flush and branch/jump redirect with MIPS delay-slot semantics.
// PARAMETERS
//  RESET_PC  32'hBFC0_0000  address of first fetch after reset
// PORTS
//  clk             in   1   core clock; all state updates on posedge
//  rst             in   1   synchronous, active-high reset
//  inst_req        out  1   fetch request; held until inst_ack
//  inst_addr       out  32  fetch address; stable while inst_req=1 and no ack
//  inst_ack        in   1   memory returns inst_rdata this cycle; request complete
//  inst_rdata      in   32  fetched instruction word
//  stallD          in   1   decode cannot accept a new instruction; IF/ID holds
//  flushD          in   1   exception flush; overrides stallD
//  flush_pc        in   32  restart address used with flushD
//  redirect_valid  in   1   branch/jump taken in D; single-cycle pulse; ignored when stallD=1
//  redirect_pc     in   32  branch/jump target
//  instrD          out  32  IF/ID instruction word
//  pcD             out  32  IF/ID instruction address
//  validD          out  1   instrD holds a real instruction (0 = bubble)
// BEHAVIOUR
//  Reset:
//   - pc_q=RESET_PC; state=FETCH; instrD=0; pcD=0; validD=0.
//   - skid buffer and redirect-pending flag cleared.
//   - inst_req=0 in the reset cycle; first request in the cycle after rst deasserts.
//  inst_req=1 in FETCH and DRAIN; inst_addr = pc_q (FETCH) or drain address (DRAIN).
//  States:
//   FETCH     request pc_q. On ack:
//             - IF/ID free (!validD || !stallD): load IF/ID with {rdata, pc_q, 1}.
//             - otherwise: capture into skid buffer -> BUFFERED.
//             - pc_q <= pending ? pend_pc : pc_q+4; pending cleared.
//   BUFFERED  no request. When !stallD: buffer -> IF/ID; buffer cleared -> FETCH.
//   DRAIN     in-flight request at the old address completes. On ack:
//             - rdata discarded; pc_q <= restart_pc -> FETCH.
//  IF/ID, no flush and !stallD: loads from buffer, else ack data, else validD=0 (bubble).
//  IF/ID, stallD=1: holds all fields.
//  Fetch latency: 1 cycle from ack to validD=1 when IF/ID is free.
//  Redirect (delay slot: the instruction after the branch always executes):
//   - delay slot already accepted (buffer valid, or ack this cycle) -> pc_q <= redirect_pc directly.
//   - otherwise -> pending=1, pend_pc=redirect_pc; applied on the next accepted ack.
//  Flush (highest priority):
//   - validD<=0, instrD<=0, buffer cleared, pending cleared.
//   - FETCH with ack same cycle: data dropped, pc_q<=flush_pc, stay FETCH.
//   - FETCH without ack: restart_pc<=flush_pc, drain address kept -> DRAIN.
//   - BUFFERED: pc_q<=flush_pc -> FETCH.
//   - DRAIN: restart_pc<=flush_pc (a newer flush replaces the older one).
//  Simultaneous flushD and redirect_valid: flush wins; redirect dropped.
//  PC arithmetic: 32-bit, wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0); bits [1:0] not checked.
//  rst mid-request: outstanding ack in the next cycle is ignored (state already FETCH, request
//   reissued); memory model must tolerate reissue.
// STRUCTURE
//  - Shared header utils/fetch_defines.vh: state encodings (FETCH/BUFFERED/DRAIN),
//    default RESET_PC, PC increment constant.
//  - One sub-module: fetch_skid_buf (1-entry {instr, pc} buffer, load/clear/valid).
//  - FSM, PC/redirect logic and IF/ID register stay in fetch_unit.
// TESTING
//  1 Reset, ack each cycle, no stall -> inst_addr BFC00000, BFC00004, BFC00008;
//    validD=1 one cycle after each ack.
//  2 stallD=1 for 3 cycles while ack arrives with validD=1 -> state BUFFERED, inst_req=0,
//    IF/ID unchanged; stallD=0 -> buffered word appears next cycle, fetch resumes at +4.
//  3 Branch at pcD=00000100, redirect_pc=00000200, delay slot in flight -> 00000104
//    accepted, next inst_addr=00000200.
//  4 Redirect in the same cycle as the delay-slot ack -> next inst_addr=target, no extra fetch.
//  5 flushD, flush_pc=BFC00380, during an outstanding request -> DRAIN, data discarded,
//    validD=0, next inst_addr=BFC00380.
//  6 flushD together with stallD and redirect_valid -> flush applied, redirect ignored,
//    IF/ID bubbled.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared types and constants for the instruction-fetch stage
package fetch_unit_pkg;

  // Fetch FSM states: FETCH requests pc_q, BUFFERED parks a word behind a stalled
  // decoder, DRAIN waits out a request made stale by a flush.
  typedef enum logic [1:0] {
    ST_FETCH    = 2'd0,
    ST_BUFFERED = 2'd1,
    ST_DRAIN    = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
  localparam logic [31:0] PC_INCR          = 32'd4;

  // Sequential successor; wraps modulo 2^32.
  function automatic logic [31:0] pc_next(input logic [31:0] pc);
    return pc + PC_INCR;
  endfunction

endpackage

// File: rtl/fetch_unit_skid_buf.sv
// rtl/fetch_unit_skid_buf.sv - one-entry {instr, pc} holding buffer for a stalled decoder
module fetch_skid_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc
);

  // Capture a word on load; clear wins so a flush never leaves a stale entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      instr <= 32'd0;
      pc    <= 32'd0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= load_instr;
      pc    <= load_pc;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - MIPS IF stage: PC, req/ack fetch port, IF/ID register, stall/flush/redirect
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_ack,
  input  logic [31:0] inst_rdata,
  input  logic        stallD,
  input  logic        flushD,
  input  logic [31:0] flush_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instrD,
  output logic [31:0] pcD,
  output logic        validD
);

  fetch_state_e state_q, state_d;

  logic [31:0] pc_q;
  logic [31:0] pend_pc_q;
  logic [31:0] restart_pc_q;
  logic        pend_q;

  logic        buf_valid;
  logic [31:0] buf_instr;
  logic [31:0] buf_pc;
  logic        buf_load;
  logic        buf_clear;

  logic        ack;
  logic        id_free;
  logic        redir;
  logic        load_ack;

  // An ack only counts against a live request; acks during reset or BUFFERED are noise.
  assign ack      = inst_ack && inst_req;
  assign id_free  = !validD || !stallD;
  assign redir    = redirect_valid && !stallD && !flushD;
  assign load_ack = (state_q == ST_FETCH) && ack && !flushD && id_free;

  assign buf_load  = (state_q == ST_FETCH) && ack && !flushD && !id_free;
  assign buf_clear = flushD || ((state_q == ST_BUFFERED) && !stallD);

  fetch_skid_buf u_skid (
    .clk        (clk),
    .rst        (rst),
    .load       (buf_load),
    .clear      (buf_clear),
    .load_instr (inst_rdata),
    .load_pc    (pc_q),
    .valid      (buf_valid),
    .instr      (buf_instr),
    .pc         (buf_pc)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_FETCH;
    else     state_q <= state_d;
  end

  // FSM next state: park on a blocked ack, drain a request orphaned by a flush.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: begin
        if (flushD) begin
          if (!ack) state_d = ST_DRAIN;
        end else if (ack && !id_free) begin
          state_d = ST_BUFFERED;
        end
      end
      ST_BUFFERED: begin
        if (flushD || !stallD) state_d = ST_FETCH;
      end
      ST_DRAIN: begin
        if (ack) state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // FSM outputs: pc_q doubles as the drain address, so the address stays stable across a flush.
  always_comb begin
    inst_req  = !rst && ((state_q == ST_FETCH) || (state_q == ST_DRAIN));
    inst_addr = pc_q;
  end

  // PC, pending-redirect and restart-address bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      pend_q       <= 1'b0;
      pend_pc_q    <= 32'd0;
      restart_pc_q <= 32'd0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (flushD) begin
            pend_q <= 1'b0;
            if (ack) pc_q <= flush_pc;
            else     restart_pc_q <= flush_pc;
          end else if (ack) begin
            // This ack is the delay slot when a redirect is live, so the target is next.
            pend_q <= 1'b0;
            if (redir)       pc_q <= redirect_pc;
            else if (pend_q) pc_q <= pend_pc_q;
            else             pc_q <= pc_next(pc_q);
          end else if (redir) begin
            // Delay slot still in flight: apply the target once it lands.
            pend_q    <= 1'b1;
            pend_pc_q <= redirect_pc;
          end
        end
        ST_BUFFERED: begin
          if (flushD) begin
            pc_q   <= flush_pc;
            pend_q <= 1'b0;
          end else if (redir) begin
            pc_q <= redirect_pc;
          end
        end
        ST_DRAIN: begin
          if (flushD) begin
            pend_q <= 1'b0;
            if (ack) pc_q <= flush_pc;
            else     restart_pc_q <= flush_pc;
          end else if (ack) begin
            pc_q <= restart_pc_q;
          end
        end
        default: pc_q <= pc_q;
      endcase
    end
  end

  // IF/ID register: flush bubbles, buffer drains first, then fresh ack data, else bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      instrD <= 32'd0;
      pcD    <= 32'd0;
      validD <= 1'b0;
    end else if (flushD) begin
      instrD <= 32'd0;
      validD <= 1'b0;
    end else if (!stallD && buf_valid) begin
      instrD <= buf_instr;
      pcD    <= buf_pc;
      validD <= 1'b1;
    end else if (load_ack) begin
      instrD <= inst_rdata;
      pcD    <= pc_q;
      validD <= 1'b1;
    end else if (!stallD) begin
      validD <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit against an instruction-stream model
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_ack;
  logic [31:0] inst_rdata;
  logic        stallD;
  logic        flushD;
  logic [31:0] flush_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] instrD;
  logic [31:0] pcD;
  logic        validD;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .inst_req       (inst_req),
    .inst_addr      (inst_addr),
    .inst_ack       (inst_ack),
    .inst_rdata     (inst_rdata),
    .stallD         (stallD),
    .flushD         (flushD),
    .flush_pc       (flush_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instrD         (instrD),
    .pcD            (pcD),
    .validD         (validD)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memword(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5A5_0F0F;
  endfunction

  // Reference model: the program-order stream decode must see, plus request-level bookkeeping.
  logic [31:0] exp_pc;
  logic [31:0] tgt;
  bit          arm;
  bit          drain;
  logic [31:0] fl_addr;
  bit          exp_lat, exp_bubble, exp_hold, chk_stable, exp_restart;
  logic [31:0] lat_pc, stable_addr, restart_addr;
  logic [64:0] hold_val;
  int          consumed;

  task automatic step(input logic st, input logic fl, input logic [31:0] fpc,
                      input logic rd, input logic [31:0] rpc, input logic ak);
    logic        ackv;
    logic [31:0] nxt;
    if (chk_stable)  check("addr_stable", {inst_req, inst_addr}, {1'b1, stable_addr});
    if (exp_restart) check("restart_addr", {inst_req, inst_addr}, {1'b1, restart_addr});
    if (exp_lat) begin
      check("lat_valid", validD, 1'b1);
      check("lat_pc", pcD, lat_pc);
      check("lat_instr", instrD, memword(lat_pc));
    end
    if (exp_bubble) begin
      check("flush_valid", validD, 1'b0);
      check("flush_instr", instrD, 32'd0);
    end
    if (exp_hold) check("stall_hold", {instrD, pcD, validD}, hold_val);

    stallD         = st;
    flushD         = fl;
    flush_pc       = fpc;
    redirect_valid = rd;
    redirect_pc    = rpc;
    ackv           = ak && inst_req;
    inst_ack       = ackv;
    inst_rdata     = ackv ? memword(inst_addr) : 32'hDEAD_BEEF;

    if (validD && !st) begin
      check("d_pc", pcD, exp_pc);
      check("d_instr", instrD, memword(exp_pc));
      consumed++;
      nxt = arm ? tgt : exp_pc + 32'd4;
      arm = 1'b0;
      if (rd && !fl) begin
        arm = 1'b1;
        tgt = rpc;
      end
      exp_pc = nxt;
    end

    exp_hold    = st && !fl && validD;
    hold_val    = {instrD, pcD, validD};
    exp_bubble  = fl;
    exp_lat     = ackv && !fl && !drain && (!validD || !st);
    lat_pc      = inst_addr;
    chk_stable  = inst_req && !ackv;
    stable_addr = inst_addr;
    exp_restart = 1'b0;
    if (fl) begin
      arm     = 1'b0;
      exp_pc  = fpc;
      fl_addr = fpc;
      drain   = inst_req && !ackv;
      if (!drain) begin
        exp_restart  = 1'b1;
        restart_addr = fpc;
      end
    end else if (ackv && drain) begin
      drain        = 1'b0;
      exp_restart  = 1'b1;
      restart_addr = fl_addr;
    end

    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic        st, fl, rd, ak;
    logic [31:0] fpc, rpc;

    rst = 1'b1; inst_ack = 1'b0; inst_rdata = 32'd0; stallD = 1'b0; flushD = 1'b0;
    flush_pc = 32'd0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    exp_pc = 32'hBFC0_0000; tgt = 32'd0; arm = 1'b0; drain = 1'b0; fl_addr = 32'd0;
    exp_lat = 1'b0; exp_bubble = 1'b0; exp_hold = 1'b0; chk_stable = 1'b0; exp_restart = 1'b0;
    lat_pc = 32'd0; stable_addr = 32'd0; restart_addr = 32'd0; hold_val = 65'd0; consumed = 0;

    repeat (2) @(negedge clk);
    check("rst_req", inst_req, 1'b0);
    check("rst_valid", validD, 1'b0);
    check("rst_instr", instrD, 32'd0);
    check("rst_pc", pcD, 32'd0);
    rst = 1'b0;
    #1;
    check("first_req", {inst_req, inst_addr}, {1'b1, 32'hBFC0_0000});

    // Back-to-back acks, no stall.
    step(0, 0, 0, 0, 0, 1);
    check("t1_addr1", inst_addr, 32'hBFC0_0004);
    step(0, 0, 0, 0, 0, 1);
    check("t1_addr2", inst_addr, 32'hBFC0_0008);
    step(0, 0, 0, 0, 0, 1);

    // Stall with a valid word in D while the next ack arrives.
    step(1, 0, 0, 0, 0, 1);
    check("t2_req0", inst_req, 1'b0);
    step(1, 0, 0, 0, 0, 1);
    check("t2_req1", inst_req, 1'b0);
    step(1, 0, 0, 0, 0, 0);
    check("t2_req2", inst_req, 1'b0);
    check("t2_held", pcD, 32'hBFC0_0008);
    step(0, 0, 0, 0, 0, 0);
    check("t2_buf_pc", {validD, pcD}, {1'b1, 32'hBFC0_000C});
    check("t2_resume", {inst_req, inst_addr}, {1'b1, 32'hBFC0_0010});

    // Flush during an outstanding request.
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 32'hBFC0_0380, 0, 0, 0);
    check("t5_drain_addr", inst_addr, 32'hBFC0_0010);
    step(0, 0, 0, 0, 0, 1);
    check("t5_restart", inst_addr, 32'hBFC0_0380);
    check("t5_discard", validD, 1'b0);

    // Branch at 0x100 with its delay slot still in flight.
    step(0, 1, 32'h0000_0100, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    check("t3_branch_pc", pcD, 32'h0000_0100);
    step(0, 0, 0, 1, 32'h0000_0200, 0);
    check("t3_slot_addr", inst_addr, 32'h0000_0104);
    step(0, 0, 0, 0, 0, 1);
    check("t3_slot_pc", pcD, 32'h0000_0104);
    check("t3_target", inst_addr, 32'h0000_0200);

    // Redirect in the same cycle as the delay-slot ack.
    step(0, 0, 0, 0, 0, 1);
    check("t4_branch_pc", pcD, 32'h0000_0200);
    step(0, 0, 0, 1, 32'h0000_0300, 1);
    check("t4_slot_pc", pcD, 32'h0000_0204);
    check("t4_target", inst_addr, 32'h0000_0300);

    // Flush together with stall and redirect.
    step(1, 1, 32'h0000_0400, 1, 32'h0000_0500, 0);
    check("t6_drain_addr", inst_addr, 32'h0000_0300);
    step(0, 0, 0, 0, 0, 1);
    check("t6_restart", inst_addr, 32'h0000_0400);
    step(0, 0, 0, 0, 0, 1);
    check("t6_no_redirect", {validD, pcD, inst_addr}, {1'b1, 32'h0000_0400, 32'h0000_0404});

    // PC wrap at the top of the address space.
    step(0, 1, 32'hFFFF_FFFC, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    check("wrap_addr", inst_addr, 32'h0000_0000);
    step(0, 0, 0, 0, 0, 1);
    check("wrap_pc", pcD, 32'h0000_0000);

    // Randomized traffic against the stream model.
    for (int i = 0; i < 3000; i++) begin
      st  = ($urandom % 4) == 0;
      fl  = ($urandom % 40) == 0;
      fpc = $urandom & 32'hFFFF_FFFC;
      rd  = validD && !st && !arm && (($urandom % 5) == 0);
      rpc = $urandom & 32'hFFFF_FFFC;
      ak  = ($urandom % 3) != 0;
      step(st, fl, fpc, rd, rpc, ak);
    end
    check("progress", consumed > 300, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
